// File: rtl/driver_pkg.sv
// Shared constants for the multi-dot H-bridge driver: FSM state codes and driver_io bit mapping.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package driver_pkg;

    // Sequencer state encoding. Plain constants keep the code readable in older netlist viewers.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_DEAD  = 3'd2;
    localparam logic [2:0] ST_FIRE  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Each channel k owns a bit pair in driver_io: p_out at [2k+1], n_out at [2k].
    localparam int P_OFS = 1;
    localparam int N_OFS = 0;

    function automatic int p_bit(input int ch);
        return 2 * ch + P_OFS;
    endfunction

    function automatic int n_bit(input int ch);
        return 2 * ch + N_OFS;
    endfunction

endpackage

// File: rtl/hbridge_channel.sv
// One H-bridge leg pair: maps enable/polarity/invert onto p/n drive levels.
// Latency: purely combinational.
// Backpressure: none; p and n are mutually exclusive by construction.
//
// Ports:
//   enable   - channel participates in this firing step
//   polarity - pattern polarity bit
//   invert   - per-channel polarity inversion
//   p_out    - high side drive
//   n_out    - low side drive
module hbridge_channel (
    input  logic enable,
    input  logic polarity,
    input  logic invert,
    output logic p_out,
    output logic n_out
);

    logic dir;

    assign dir   = polarity ^ invert;
    // A disabled channel keeps both sides off; an enabled one drives exactly one side.
    assign p_out = enable & dir;
    assign n_out = enable & ~dir;

endmodule

// File: rtl/multi_dot_driver.sv
// Sequences firing patterns from a small pattern RAM onto CHANNELS H-bridges with dead time.
// Latency: start -> 1 fetch cycle -> DEAD_TIME all-off cycles -> max(pulse_len,1) fire cycles per step.
// Backpressure: none; start and wr_en are ignored (wr_en flags wr_err) while a sequence is running.
//
// Ports:
//   clock, reset          - system clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data - pattern write, data = {enable[CHANNELS], polarity[CHANNELS]}
//   start, seq_first, seq_last, pulse_len - sequence request and its parameters
//   output_active         - master arm, filtered over ACTIVE_FILT cycles
//   inverter_select       - per-channel polarity inversion, latched at start
//   busy, done, abort, wr_err - status; done/abort/wr_err are one-cycle pulses
//   driver_io             - bridge drive, [2k+1]=p_out, [2k]=n_out of channel k
module multi_dot_driver
    import driver_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int MEM_DEPTH   = 48,
    parameter int ADDR_W      = 6,
    parameter int PULSE_W     = 16,
    parameter int DEAD_TIME   = 2,
    parameter int ACTIVE_FILT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [2*CHANNELS-1:0] wr_data,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     seq_first,
    input  logic [ADDR_W-1:0]     seq_last,
    input  logic [PULSE_W-1:0]    pulse_len,
    input  logic                  output_active,
    input  logic [CHANNELS-1:0]   inverter_select,
    output logic                  busy,
    output logic                  done,
    output logic                  abort,
    output logic                  wr_err,
    output logic [2*CHANNELS-1:0] driver_io
);

    localparam int DW = 2 * CHANNELS;
    localparam int FW = $clog2(ACTIVE_FILT + 1);

    logic [2:0]          state;
    logic [FW-1:0]       filt_cnt;
    logic                qual;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W-1:0]   last_q;
    logic [PULSE_W-1:0]  plen_q;
    logic [PULSE_W-1:0]  fire_len;
    logic [PULSE_W-1:0]  step_cnt;
    logic [CHANNELS-1:0] inv_q;
    logic [DW-1:0]       pat_q;
    logic [DW-1:0]       rd_dat;
    logic [DW-1:0]       fire_vec;
    logic [DW-1:0]       drv_q;
    logic                abort_q;
    logic                wr_err_q;
    logic                wr_ok;
    logic                wr_bad;
    logic                in_seq;
    logic [ADDR_W-1:0]   next_addr;

    logic [DW-1:0] mem [MEM_DEPTH];

    // ------------------------------------------------------------------
    // output_active qualification: saturating run-length counter.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            filt_cnt <= '0;
        end else if (!output_active) begin
            filt_cnt <= '0;
        end else if (!qual) begin
            filt_cnt <= filt_cnt + FW'(1);
        end
    end

    assign qual = (filt_cnt == FW'(ACTIVE_FILT));

    // ------------------------------------------------------------------
    // Pattern memory. Not reset so patterns survive a reset.
    // ------------------------------------------------------------------
    assign wr_ok  = wr_en && (state == ST_IDLE) && (int'(wr_addr) < MEM_DEPTH);
    assign wr_bad = wr_en && !wr_ok;

    always_ff @(posedge clock) begin
        if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Out-of-range start addresses read as an all-disabled pattern.
    assign rd_dat = (int'(addr) < MEM_DEPTH) ? mem[addr] : '0;

    // ------------------------------------------------------------------
    // Per-channel mapping of the fetched pattern to p/n levels.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        hbridge_channel u_ch (
            .enable   (pat_q[CHANNELS + k]),
            .polarity (pat_q[k]),
            .invert   (inv_q[k]),
            .p_out    (fire_vec[p_bit(k)]),
            .n_out    (fire_vec[n_bit(k)])
        );
    end

    // ------------------------------------------------------------------
    // Sequencer.
    // ------------------------------------------------------------------
    assign fire_len  = (plen_q == '0) ? PULSE_W'(1) : plen_q;
    assign next_addr = (int'(addr) == MEM_DEPTH - 1) ? '0 : addr + ADDR_W'(1);
    assign in_seq    = (state == ST_FETCH) || (state == ST_DEAD) || (state == ST_FIRE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            addr     <= '0;
            last_q   <= '0;
            plen_q   <= '0;
            inv_q    <= '0;
            pat_q    <= '0;
            step_cnt <= '0;
            drv_q    <= '0;
            abort_q  <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            abort_q  <= 1'b0;
            wr_err_q <= wr_bad;

            if (in_seq && !qual) begin
                // Arm lost mid-sequence: outputs are already gated off, unwind to IDLE.
                state    <= ST_IDLE;
                drv_q    <= '0;
                step_cnt <= '0;
                abort_q  <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        drv_q <= '0;
                        if (start && qual) begin
                            addr     <= seq_first;
                            last_q   <= seq_last;
                            plen_q   <= pulse_len;
                            inv_q    <= inverter_select;
                            step_cnt <= '0;
                            state    <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        pat_q    <= rd_dat;
                        step_cnt <= '0;
                        state    <= ST_DEAD;
                    end
                    ST_DEAD: begin
                        if (step_cnt == PULSE_W'(DEAD_TIME - 1)) begin
                            // Load the drive register so FIRE starts with the pattern on the pins.
                            step_cnt <= '0;
                            drv_q    <= fire_vec;
                            state    <= ST_FIRE;
                        end else begin
                            step_cnt <= step_cnt + PULSE_W'(1);
                        end
                    end
                    ST_FIRE: begin
                        if (step_cnt == fire_len - PULSE_W'(1)) begin
                            step_cnt <= '0;
                            drv_q    <= '0;
                            if (addr == last_q) begin
                                state <= ST_DONE;
                            end else begin
                                addr  <= next_addr;
                                state <= ST_FETCH;
                            end
                        end else begin
                            step_cnt <= step_cnt + PULSE_W'(1);
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                        drv_q <= '0;
                    end
                endcase
            end
        end
    end

    // Combinational kill path: a dropped arm removes drive in the same cycle it is seen.
    assign driver_io = drv_q & {DW{qual}};
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign abort     = abort_q;
    assign wr_err    = wr_err_q;

endmodule
